// File: rtl/quad_enc_emulator_if.sv
// Burst request channel for the quadrature encoder emulator.
// The master offers a signed 4x edge count; the emulator raises cnt_ready when idle.
interface quad_enc_emulator_if;
  logic               cnt_valid;
  logic signed [15:0] cnt_in;
  logic               cnt_ready;

  modport master (output cnt_valid, output cnt_in, input cnt_ready);
  modport slave  (input cnt_valid, input cnt_in, output cnt_ready);
endinterface

// File: rtl/quad_enc_emulator.sv
// Quadrature encoder emulator: replays one gate's signed edge count as evenly
// spaced A/B transitions, clipped to what fits in a measurement gate.
module quad_enc_emulator #(
  parameter int GATE_CLOCKS     = 500000,
  parameter int EDGE_GAP_CYC    = 54,
  parameter int HEAD_DELAY_CYC  = 54,
  parameter int TAIL_SAFETY_CYC = 54
) (
  input  logic                aclk,
  input  logic                rst_n,
  quad_enc_emulator_if.slave  cnt,
  input  logic                flush,
  output logic                enc_a,
  output logic                enc_b,
  output logic                burst_done,
  output logic                sat_flag,
  output logic signed [31:0]  pos_out
);

  localparam int CAPACITY = (GATE_CLOCKS - HEAD_DELAY_CYC - TAIL_SAFETY_CYC) / EDGE_GAP_CYC;
  localparam logic [16:0] CAP17 = CAPACITY[16:0];
  // Counters load two short: one cycle is spent in EMIT, one in the accept/transition edge.
  localparam int HEAD_LOAD = (HEAD_DELAY_CYC >= 2) ? HEAD_DELAY_CYC - 2 : 0;
  localparam int GAP_LOAD  = (EDGE_GAP_CYC >= 2) ? EDGE_GAP_CYC - 2 : 0;

  typedef enum logic [1:0] {IDLE, HEAD, EMIT, GAP} state_t;

  state_t       state;
  logic         ready_r;
  logic         dir;
  logic [16:0]  remaining;
  logic [31:0]  wait_cnt;
  logic [17:0]  clip_res;
  logic         accept;

  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    if (v[15]) return 17'd0 - {v[15], v};
    else       return {1'b0, v};
  endfunction

  // Returns {clipped, magnitude limited to CAPACITY}.
  function automatic logic [17:0] clip_mag(input logic [16:0] m);
    if (int'({15'd0, m}) > CAPACITY) return {1'b1, CAP17};
    else                             return {1'b0, m};
  endfunction

  function automatic logic [1:0] step_ab(input logic [1:0] ab, input logic fwd);
    case (ab)
      2'b00:   return fwd ? 2'b01 : 2'b10;
      2'b01:   return fwd ? 2'b11 : 2'b00;
      2'b11:   return fwd ? 2'b10 : 2'b01;
      default: return fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  assign cnt.cnt_ready = ready_r;
  assign accept        = cnt.cnt_valid & ready_r;

  always_comb begin
    clip_res = clip_mag(abs17(cnt.cnt_in));
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready_r    <= 1'b0;
      dir        <= 1'b1;
      remaining  <= '0;
      wait_cnt   <= '0;
      enc_a      <= 1'b0;
      enc_b      <= 1'b0;
      burst_done <= 1'b0;
      sat_flag   <= 1'b0;
      pos_out    <= '0;
    end else begin
      burst_done <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        ready_r <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              ready_r   <= 1'b0;
              dir       <= ~cnt.cnt_in[15];
              sat_flag  <= clip_res[17];
              remaining <= clip_res[16:0];
              if (clip_res[16:0] == 17'd0) begin
                burst_done <= 1'b1;
              end else begin
                wait_cnt <= 32'(HEAD_LOAD);
                state    <= (HEAD_DELAY_CYC >= 2) ? HEAD : EMIT;
              end
            end else begin
              ready_r <= 1'b1;
            end
          end
          HEAD, GAP: begin
            if (wait_cnt == 32'd0) state <= EMIT;
            else                   wait_cnt <= wait_cnt - 32'd1;
          end
          EMIT: begin
            {enc_a, enc_b} <= step_ab({enc_a, enc_b}, dir);
            pos_out        <= dir ? pos_out + 32'sd1 : pos_out - 32'sd1;
            remaining      <= remaining - 17'd1;
            if (remaining == 17'd1) begin
              burst_done <= 1'b1;
              state      <= IDLE;
            end else begin
              wait_cnt <= 32'(GAP_LOAD);
              state    <= (EDGE_GAP_CYC >= 2) ? GAP : EMIT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
